byte_serializer: RTL
====================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 flush  input  1  synchronous abort; clears frame in progress and holding buffer.
REQ-005 in_data  input  8  parallel byte to transmit.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 bit_out  output  1  serial data bit, MSB first.
REQ-009 bit_valid  output  1  bit_out carries a frame bit this cycle.
REQ-010 frame_start  output  1  high with first bit of each frame.
REQ-011 frame_last  output  1  high with last bit of each frame.
REQ-012 The block SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-013 Byte accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal NOT hold_full, combinationally.
REQ-014 Storage: 8-bit shift register plus 8-bit holding register with hold_full flag; 4-bit bit counter.
REQ-015 States: IDLE (no frame), SHIFT (frame in progress); bit_valid SHALL be 1 exactly in SHIFT.
REQ-016 IDLE + accept: byte loaded into shift register, counter=0, go to SHIFT; first bit appears the cycle after the accepting edge (latency 1).
REQ-017 bit_out SHALL equal shift register bit 7 in SHIFT, 0 in IDLE.
REQ-018 SHIFT, counter below last index: each edge shifts left by one (LSB fills 0), counter+1.
REQ-019 SHIFT at last bit (counter=7; 8 with parity): if hold_full, load holding into shift register, clear hold_full, counter=0, stay SHIFT; else if accept this edge, load in_data directly, stay SHIFT; else go to IDLE.
REQ-020 Back-to-back bytes SHALL produce consecutive frames with no idle cycle between them.
REQ-021 Accept during SHIFT that is not consumed per REQ-019 SHALL go to holding register and set hold_full.
REQ-022 frame_start=1 when SHIFT and counter=0; frame_last=1 when SHIFT and counter=last index.
REQ-023 flush=1 on an edge: go to IDLE, clear shift register, counter and hold_full; any byte offered that cycle SHALL be discarded; flush SHALL override accept.
REQ-024 in_data changes while in_valid=0 or in_ready=0 SHALL have no effect.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, shift register=0, holding=0, hold_full=0, counter=0.
REQ-026 Outputs during/after reset: bit_out=0, bit_valid=0, frame_start=0, frame_last=0, in_ready=1.
REQ-027 Reset mid-frame SHALL drop the partial frame and any held byte; no bits resume after release.

Configuration
REQ-028 Macro BYTE_SERIALIZER_PARITY_EN: when defined, each frame SHALL be 9 bits: 8 data bits MSB first, then even-parity bit (XOR of the 8 data bits), last index 8, frame_last on the parity bit.
REQ-029 When BYTE_SERIALIZER_PARITY_EN is undefined, frames SHALL be 8 bits, last index 7; no parity logic present.

Verification
REQ-030 Single byte: rst pulse, offer 0xA5 one cycle -> bit_out 1,0,1,0,0,1,0,1 on next 8 cycles, bit_valid=1 for exactly those 8, frame_start on first, frame_last on eighth, then IDLE.
REQ-031 Back-to-back: offer 0x3C then 0xC3 on consecutive accepted cycles -> 16 contiguous bit_valid cycles: 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1; in_ready low while 0xC3 held.
REQ-032 Backpressure: in_valid held high with 0x01,0x02,0x03 -> in_ready drops after second accept, re-asserts on edge 0x02 leaves holding; all three frames emitted in order, none lost or duplicated.
REQ-033 Flush: offer 0xFF, assert flush after bit 3 -> bit_valid=0 next cycle, hold_full=0; next offered 0x81 serialises fully as 1,0,0,0,0,0,0,1.
REQ-034 Async reset: assert rst mid-cycle during frame of 0x55 with 0xAA held -> outputs zero immediately, in_ready=1; no bits of 0x55 or 0xAA after release.
REQ-035 Parity (macro defined): offer 0x07 -> 9 bits 0,0,0,0,0,1,1,1,1; offer 0x03 -> parity bit 0; frame_last on ninth bit.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: 8-bit parallel-to-serial framer, MSB first, with a one-byte holding buffer.
// Define BYTE_SERIALIZER_PARITY_EN to append an even-parity bit to every frame (9-bit frames).
module byte_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       frame_start,
    output logic       frame_last
);

    // state | meaning
    // IDLE  | no frame on the line, shift register empty
    // SHIFT | frame in progress, cnt_q indexes the bit being driven

`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_q, state_nxt;
    logic [7:0] shift_q, shift_nxt;
    logic [7:0] hold_q, hold_nxt;
    logic       hold_full_q, hold_full_nxt;
    logic [3:0] cnt_q, cnt_nxt;
    logic       accept;
    logic       last_bit;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic       par_q, par_nxt;
`endif

    assign in_ready = ~hold_full_q;
    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            cnt_q       <= 4'd0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            shift_q     <= shift_nxt;
            hold_q      <= hold_nxt;
            hold_full_q <= hold_full_nxt;
            cnt_q       <= cnt_nxt;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_q       <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state_q;
        shift_nxt     = shift_q;
        hold_nxt      = hold_q;
        hold_full_nxt = hold_full_q;
        cnt_nxt       = cnt_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
        par_nxt       = par_q;
`endif
        if (flush) begin
            // flush wins over any byte offered in the same cycle
            state_nxt     = IDLE;
            shift_nxt     = 8'h00;
            hold_nxt      = 8'h00;
            hold_full_nxt = 1'b0;
            cnt_nxt       = 4'd0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_nxt       = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_nxt = SHIFT;
                        shift_nxt = in_data;
                        cnt_nxt   = 4'd0;
`ifdef BYTE_SERIALIZER_PARITY_EN
                        par_nxt   = ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shift_nxt = {shift_q[6:0], 1'b0};
                        cnt_nxt   = cnt_q + 4'd1;
                        if (accept) begin
                            hold_nxt      = in_data;
                            hold_full_nxt = 1'b1;
                        end
                    end else if (hold_full_q) begin
                        shift_nxt     = hold_q;
                        hold_full_nxt = 1'b0;
                        cnt_nxt       = 4'd0;
`ifdef BYTE_SERIALIZER_PARITY_EN
                        par_nxt       = ^hold_q;
`endif
                    end else if (accept) begin
                        shift_nxt = in_data;
                        cnt_nxt   = 4'd0;
`ifdef BYTE_SERIALIZER_PARITY_EN
                        par_nxt   = ^in_data;
`endif
                    end else begin
                        state_nxt = IDLE;
                        shift_nxt = 8'h00;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bit_valid   = (state_q == SHIFT);
    assign frame_start = bit_valid & (cnt_q == 4'd0);
    assign frame_last  = bit_valid & last_bit;

`ifdef BYTE_SERIALIZER_PARITY_EN
    // parity bit rides after the data bits; the shift register is empty by then
    assign bit_out = bit_valid & (last_bit ? par_q : shift_q[7]);
`else
    assign bit_out = bit_valid & shift_q[7];
`endif

endmodule
